// File: rtl/rf_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler_pkg
// Shared types for the register-file write-back scheduler slice:
//   regbits_t  - 5-bit register select
//   word_t     - 32-bit data word
//   wb_state_t - arbiter states (NORMAL, FORCE_M)
//   WB_CNT_W   - width of the secondary-starvation wait counter
// -----------------------------------------------------------------------------
package rf_wb_scheduler_pkg;

  localparam int WB_CNT_W = 4;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_M = 1'b1
  } wb_state_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler_if
// Write requests into the scheduler from the two write-back sources.
//   p_*  primary (in-order pipeline WB stage)
//   m_*  secondary (multi-cycle unit / miss return)
// Each source: valid/wsel/wdat driven by the requester, ready by the scheduler.
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface rf_wb_scheduler_if;
  import rf_wb_scheduler_pkg::*;

  logic     p_valid;
  logic     p_ready;
  regbits_t p_wsel;
  word_t    p_wdat;

  logic     m_valid;
  logic     m_ready;
  regbits_t m_wsel;
  word_t    m_wdat;

  modport master (
    output p_valid, p_wsel, p_wdat, m_valid, m_wsel, m_wdat,
    input  p_ready, m_ready
  );

  modport slave (
    input  p_valid, p_wsel, p_wdat, m_valid, m_wsel, m_wdat,
    output p_ready, m_ready
  );
endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Busy vector for registers reserved by in-flight multi-cycle operations.
//   CLK, nRST   clock / async active-low reset (clears all reservations)
//   i_set_en    reserve i_set_sel (ignored for r0)
//   i_clr_en    release i_clr_sel (secondary write completed)
//   i_rsel1/2   decode read selects
//   o_hazard    a read select hits a reserved register (combinational)
// A set and clear of the same register in one cycle leaves it reserved.
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     i_set_en,
  input  regbits_t i_set_sel,
  input  logic     i_clr_en,
  input  regbits_t i_clr_sel,
  input  regbits_t i_rsel1,
  input  regbits_t i_rsel2,
  output logic     o_hazard
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_next;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_sel] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_sel] = 1'b1;
    // Set applied after clear so a fresh reservation survives a same-cycle release.
    w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign o_hazard = r_busy[i_rsel1] | r_busy[i_rsel2];

endmodule

// File: rtl/rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler
// Arbitrates the single register-file write port between the primary WB
// stage and a multi-cycle secondary, registers the winning write, and keeps
// a scoreboard of registers reserved by multi-cycle ops.
//   CLK, nRST             clock / async active-low reset
//   wb (slave)            primary/secondary valid-ready write requests
//   alloc_en, alloc_sel   reserve a destination for a multi-cycle op
//   rsel1, rsel2, hazard  decode read selects and reservation hit
//   rf_WEN/rf_wsel/rf_wdat registered register-file write port
// Optional feature: define RF_WB_STARVE_GUARD_EN to force-grant the secondary
// for one cycle after it has waited STARVE_MAX consecutive cycles (1..15).
// Without it the primary has strict priority.
// -----------------------------------------------------------------------------
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  rf_wb_scheduler_if.slave  wb,
  input  logic              alloc_en,
  input  regbits_t          alloc_sel,
  input  regbits_t          rsel1,
  input  regbits_t          rsel2,
  output logic              hazard,
  output logic              rf_WEN,
  output regbits_t          rf_wsel,
  output word_t             rf_wdat
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("rf_wb_scheduler: STARVE_MAX must be in 1..15");
  end

  logic w_p_xfer;
  logic w_m_xfer;

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [WB_CNT_W-1:0] STARVE_LIM = WB_CNT_W'(STARVE_MAX);

  wb_state_t           r_state;
  logic [WB_CNT_W-1:0] r_wait_cnt;
  logic [WB_CNT_W-1:0] w_cnt_next;

  always_comb begin
    wb.p_ready = 1'b1;
    wb.m_ready = !wb.p_valid;
    if (r_state == FORCE_M) begin
      wb.p_ready = 1'b0;
      wb.m_ready = 1'b1;
    end
  end

  // Counts consecutive stalled cycles of a pending secondary; any gap or grant restarts it.
  always_comb begin
    w_cnt_next = '0;
    if (wb.m_valid && !wb.m_ready)
      w_cnt_next = (r_wait_cnt >= STARVE_LIM) ? STARVE_LIM : r_wait_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= NORMAL;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        NORMAL: begin
          if (w_cnt_next == STARVE_LIM) begin
            r_state    <= FORCE_M;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_cnt_next;
          end
        end
        FORCE_M: begin
          r_state    <= NORMAL;
          r_wait_cnt <= w_cnt_next;
        end
        default: begin
          r_state    <= NORMAL;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    wb.p_ready = 1'b1;
    wb.m_ready = !wb.p_valid;
  end
`endif

  assign w_p_xfer = wb.p_valid && wb.p_ready;
  assign w_m_xfer = wb.m_valid && wb.m_ready;

  // The two grants are mutually exclusive by construction of the ready terms.
  // Writes to r0 complete the handshake but never raise the enable.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rf_WEN  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else if (w_p_xfer) begin
      rf_WEN  <= (wb.p_wsel != '0);
      rf_wsel <= wb.p_wsel;
      rf_wdat <= wb.p_wdat;
    end else if (w_m_xfer) begin
      rf_WEN  <= (wb.m_wsel != '0);
      rf_wsel <= wb.m_wsel;
      rf_wdat <= wb.m_wdat;
    end else begin
      rf_WEN  <= 1'b0;
    end
  end

  rf_scoreboard u_scoreboard (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_set_en  (alloc_en),
    .i_set_sel (alloc_sel),
    .i_clr_en  (w_m_xfer),
    .i_clr_sel (wb.m_wsel),
    .i_rsel1   (rsel1),
    .i_rsel2   (rsel2),
    .o_hazard  (hazard)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_scheduler
// Directed self-checking bench for rf_wb_scheduler with a behavioural
// register file that captures the write port on the falling edge.
// Inputs change 1 time unit after the rising edge; outputs are checked
// away from the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_wb_scheduler;
  import rf_wb_scheduler_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  logic     alloc_en;
  regbits_t alloc_sel, rsel1, rsel2;
  logic     hazard, rf_WEN;
  regbits_t rf_wsel;
  word_t    rf_wdat;

  word_t    rf_model [32];
  int       n_pass  = 0;
  int       n_total = 0;

  always #5 CLK = ~CLK;

  rf_wb_scheduler_if bus ();

  rf_wb_scheduler #(.STARVE_MAX(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .wb        (bus),
    .alloc_en  (alloc_en),
    .alloc_sel (alloc_sel),
    .rsel1     (rsel1),
    .rsel2     (rsel2),
    .hazard    (hazard),
    .rf_WEN    (rf_WEN),
    .rf_wsel   (rf_wsel),
    .rf_wdat   (rf_wdat)
  );

  // Register file: r0 hardwired to zero, capture on falling edge.
  always @(negedge CLK) begin
    if (rf_WEN && rf_wsel != 5'd0) rf_model[rf_wsel] <= rf_wdat;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_valid = 1'b0; bus.p_wsel = '0; bus.p_wdat = '0;
    bus.m_valid = 1'b0; bus.m_wsel = '0; bus.m_wdat = '0;
    alloc_en = 1'b0; alloc_sel = '0; rsel1 = '0; rsel2 = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    #12;
    n_total++; if (rf_WEN !== 1'b0) $display("FAIL reset_wen: got %b want 0", rf_WEN); else n_pass++;
    n_total++; if (rf_wsel !== 5'd0) $display("FAIL reset_wsel: got %0d want 0", rf_wsel); else n_pass++;
    n_total++; if (rf_wdat !== 32'h0) $display("FAIL reset_wdat: got %h want 0", rf_wdat); else n_pass++;
    n_total++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %b want 0", hazard); else n_pass++;
    n_total++; if (bus.p_ready !== 1'b1) $display("FAIL reset_p_ready: got %b want 1", bus.p_ready); else n_pass++;
    n_total++; if (bus.m_ready !== 1'b1) $display("FAIL reset_m_ready_idle: got %b want 1", bus.m_ready); else n_pass++;
    bus.p_valid = 1'b1;
    #1;
    n_total++; if (bus.m_ready !== 1'b0) $display("FAIL reset_m_ready_pvalid: got %b want 0", bus.m_ready); else n_pass++;
    bus.p_valid = 1'b0;
    nRST = 1'b1;
    step();
  endtask

  task automatic test_primary();
    bus.p_valid = 1'b1; bus.p_wsel = 5'd5; bus.p_wdat = 32'hDEADBEEF;
    #1;
    n_total++; if (bus.p_ready !== 1'b1) $display("FAIL prim_p_ready: got %b want 1", bus.p_ready); else n_pass++;
    step();
    bus.p_valid = 1'b0;
    n_total++; if (rf_WEN !== 1'b1) $display("FAIL prim_wen: got %b want 1", rf_WEN); else n_pass++;
    n_total++; if (rf_wsel !== 5'd5) $display("FAIL prim_wsel: got %0d want 5", rf_wsel); else n_pass++;
    n_total++; if (rf_wdat !== 32'hDEADBEEF) $display("FAIL prim_wdat: got %h want deadbeef", rf_wdat); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if (rf_model[5] !== 32'hDEADBEEF) $display("FAIL prim_readback_r5: got %h want deadbeef", rf_model[5]); else n_pass++;
    step();
    n_total++; if (rf_WEN !== 1'b0) $display("FAIL prim_wen_drop: got %b want 0", rf_WEN); else n_pass++;
    n_total++; if (rf_wsel !== 5'd5) $display("FAIL prim_wsel_hold: got %0d want 5", rf_wsel); else n_pass++;
  endtask

  task automatic test_starvation();
    logic exp_m, exp_p;
    bus.p_valid = 1'b1; bus.p_wsel = 5'd1; bus.p_wdat = 32'h1111_1111;
    bus.m_valid = 1'b1; bus.m_wsel = 5'd2; bus.m_wdat = 32'h2222_2222;
    for (int c = 1; c <= 12; c++) begin
      #1;
`ifdef RF_WB_STARVE_GUARD_EN
      exp_m = (c % 5 == 0);
`else
      exp_m = 1'b0;
`endif
      exp_p = !exp_m;
      n_total++; if (bus.m_ready !== exp_m) $display("FAIL starve_m_ready c%0d: got %b want %b", c, bus.m_ready, exp_m); else n_pass++;
      n_total++; if (bus.p_ready !== exp_p) $display("FAIL starve_p_ready c%0d: got %b want %b", c, bus.p_ready, exp_p); else n_pass++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_alloc_clear();
    alloc_en = 1'b1; alloc_sel = 5'd9; rsel1 = 5'd9;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL alloc_same_cycle: got %b want 0", hazard); else n_pass++;
    step();
    alloc_en = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b1) $display("FAIL alloc_hazard: got %b want 1", hazard); else n_pass++;
    bus.m_valid = 1'b1; bus.m_wsel = 5'd9; bus.m_wdat = 32'hCAFEF00D;
    #1;
    n_total++; if (bus.m_ready !== 1'b1) $display("FAIL alloc_m_ready: got %b want 1", bus.m_ready); else n_pass++;
    n_total++; if (hazard !== 1'b1) $display("FAIL alloc_hazard_xfer: got %b want 1", hazard); else n_pass++;
    step();
    bus.m_valid = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL clear_hazard: got %b want 0", hazard); else n_pass++;
    n_total++; if (rf_WEN !== 1'b1 || rf_wsel !== 5'd9) $display("FAIL clear_port: got wen=%b wsel=%0d want wen=1 wsel=9", rf_WEN, rf_wsel); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if (rf_model[9] !== 32'hCAFEF00D) $display("FAIL clear_readback_r9: got %h want cafef00d", rf_model[9]); else n_pass++;
    step();
    rsel1 = '0;
  endtask

  task automatic test_set_wins();
    alloc_en = 1'b1; alloc_sel = 5'd7; rsel2 = 5'd7;
    step();
    bus.m_valid = 1'b1; bus.m_wsel = 5'd7; bus.m_wdat = 32'h0000_0077;
    #1;
    n_total++; if (bus.m_ready !== 1'b1) $display("FAIL setwins_m_ready: got %b want 1", bus.m_ready); else n_pass++;
    n_total++; if (hazard !== 1'b1) $display("FAIL setwins_hazard_pre: got %b want 1", hazard); else n_pass++;
    step();
    alloc_en = 1'b0; bus.m_valid = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b1) $display("FAIL setwins_hazard_post: got %b want 1", hazard); else n_pass++;
    step();
    n_total++; if (hazard !== 1'b1) $display("FAIL setwins_hazard_hold: got %b want 1", hazard); else n_pass++;
    rsel2 = '0;
  endtask

  task automatic test_r0();
    bus.m_valid = 1'b1; bus.m_wsel = 5'd0; bus.m_wdat = 32'h0000_1234;
    #1;
    n_total++; if (bus.m_ready !== 1'b1) $display("FAIL r0_m_ready: got %b want 1", bus.m_ready); else n_pass++;
    step();
    bus.m_valid = 1'b0;
    n_total++; if (rf_WEN !== 1'b0) $display("FAIL r0_wen: got %b want 0", rf_WEN); else n_pass++;
    @(negedge CLK); #1;
    n_total++; if (rf_model[0] !== 32'h0) $display("FAIL r0_readback: got %h want 0", rf_model[0]); else n_pass++;
    step();
    alloc_en = 1'b1; alloc_sel = 5'd0; rsel1 = 5'd0; rsel2 = 5'd0;
    step();
    alloc_en = 1'b0;
    #1;
    n_total++; if (hazard !== 1'b0) $display("FAIL r0_alloc_hazard: got %b want 0", hazard); else n_pass++;
  endtask

  task automatic test_async_reset();
    alloc_en = 1'b1; alloc_sel = 5'd3; rsel1 = 5'd3;
    bus.p_valid = 1'b1; bus.p_wsel = 5'd4; bus.p_wdat = 32'h0000_0055;
    step();
    alloc_en = 1'b0; bus.p_valid = 1'b0;
    #1;
    n_total++; if (rf_WEN !== 1'b1) $display("FAIL arst_pre_wen: got %b want 1", rf_WEN); else n_pass++;
    n_total++; if (hazard !== 1'b1) $display("FAIL arst_pre_hazard: got %b want 1", hazard); else n_pass++;
    #2;
    nRST = 1'b0;
    #1;
    n_total++; if (rf_WEN !== 1'b0) $display("FAIL arst_wen: got %b want 0", rf_WEN); else n_pass++;
    n_total++; if (rf_wsel !== 5'd0) $display("FAIL arst_wsel: got %0d want 0", rf_wsel); else n_pass++;
    n_total++; if (rf_wdat !== 32'h0) $display("FAIL arst_wdat: got %h want 0", rf_wdat); else n_pass++;
    n_total++; if (hazard !== 1'b0) $display("FAIL arst_hazard: got %b want 0", hazard); else n_pass++;
    #2;
    nRST = 1'b1;
    step();
    n_total++; if (hazard !== 1'b0) $display("FAIL arst_reservation_lost: got %b want 0", hazard); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    test_reset();
    test_primary();
    test_starvation();
    test_alloc_clear();
    test_set_wins();
    test_r0();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the single write port of the 32×32 register file. It arbitrates between the in-order pipeline write-back (primary) and a multi-cycle unit such as a divider or miss-return path (secondary), and registers the winning write onto the port. A 32-entry scoreboard tracks registers reserved by in-flight multi-cycle operations and raises a read hazard for the decode stage. It sits between the WB stage, the multi-cycle unit and `register_file`.

## Interface
- STARVE_MAX, 4, consecutive cycles the secondary may wait before it is force-granted (range 1–15).

- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- p_valid  in  1  primary write request.
- p_ready  out  1  primary accepted.
- p_wsel  in  5  primary destination.
- p_wdat  in  32  primary data.
- m_valid  in  1  secondary write request.
- m_ready  out  1  secondary accepted.
- m_wsel  in  5  secondary destination.
- m_wdat  in  32  secondary data.
- alloc_en  in  1  reserve a destination for a multi-cycle op.
- alloc_sel  in  5  register to reserve.
- rsel1, rsel2  in  5 each  decode read selects.
- hazard  out  1  a read select hits a reserved register.
- rf_WEN  out  1  register-file write enable.
- rf_wsel  out  5  register-file write select.
- rf_wdat  out  32  register-file write data.

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. Once valid is asserted, the requester holds valid, wsel and wdat stable until the transfer completes.
- Arbitration FSM, states NORMAL and FORCE_M:
  - NORMAL: p_ready = 1; m_ready = !p_valid.
  - FORCE_M: m_ready = 1; p_ready = 0.
  - NORMAL → FORCE_M when the wait counter reaches STARVE_MAX.
  - FORCE_M → NORMAL after exactly one cycle, whether or not m_valid is asserted.
- Wait counter (4 bits):
  - Increments when m_valid && !m_ready.
  - Clears on an m transfer, when m_valid is low, or on entering FORCE_M.
  - Saturates at STARVE_MAX.
- Output register: the winning transfer loads rf_WEN/rf_wsel/rf_wdat at the next rising edge. With no transfer, rf_WEN = 0 and wsel/wdat hold their last values.
- Writes to register 0: the handshake completes normally, rf_WEN stays 0, and the scoreboard is untouched.
- Scoreboard busy[31:0]:
  - Set busy[alloc_sel] on alloc_en when alloc_sel ≠ 0.
  - Clear busy[m_wsel] on an m transfer.
  - Simultaneous set and clear of the same register: set wins (the new reservation persists).
  - A primary write to a busy register writes the data and leaves the busy bit set.
- hazard = busy[rsel1] | busy[rsel2], combinational. busy[0] is always 0.

## Timing
- Reset values: rf_WEN 0, rf_wsel 0, rf_wdat 0, busy all 0, state NORMAL, counter 0, hazard 0. p_ready resets to 1; m_ready resets to !p_valid.
- Latency: a transfer in cycle t drives rf_WEN in cycle t+1, and the register file captures it at the falling edge of t+1.
- Scoreboard clear takes effect at the rising edge ending cycle t, so hazard drops in t+1. A decode read in t+1 then sees the new data after the falling edge.
- Reset mid-operation: pending output writes are discarded and all reservations are lost. The multi-cycle unit must also be reset.
- alloc_en in cycle t raises hazard from t+1.

## Configuration
- RF_WB_STARVE_GUARD_EN defined: wait counter and FORCE_M state are present as described.
- Undefined: strict primary priority. The FSM stays in NORMAL, STARVE_MAX is ignored, and m_ready = !p_valid always.

## Structure
- Add to cpu_types_pkg:
  - regbits_t (5-bit select) and word_t (already present).
  - wb_state_t enum {NORMAL, FORCE_M}.
  - WB_CNT_W = 4.
- Sub-module `rf_scoreboard`: busy vector with set/clear/set-wins logic and the two-port hazard lookup. The arbiter FSM and output register stay in the top module.

## Test plan
- Reset, then p_valid=1, p_wsel=5, p_wdat=0xDEADBEEF → next cycle rf_WEN=1, rf_wsel=5, rf_wdat=0xDEADBEEF. Register-file readback of r5 = 0xDEADBEEF.
- p_valid and m_valid held high continuously, STARVE_MAX=4 → m_ready=1 in exactly cycle 5, then every 5th cycle; p_ready=0 only in those cycles. With the macro undefined, m_ready never rises.
- alloc_en with alloc_sel=9, then rsel1=9 → hazard=1 from the next cycle. m transfer to r9 → hazard=0 in the following cycle, and rsel1=9 reads the new data.
- Same cycle: alloc_sel=7 and m transfer with m_wsel=7 → busy[7] remains 1, hazard stays 1 for rsel2=7.
- m transfer to r0 with data 0x1234 → m_ready completes, rf_WEN=0, r0 reads 0. alloc_sel=0 → hazard remains 0.
- Assert nRST low while rf_WEN=1 and busy[3]=1 → outputs and busy clear immediately (asynchronously), before the next clock edge.
